// File: rtl/move_issuer_pkg.sv
// Shared widths, phase codes and request layout for the move-instruction stream.
package move_issuer_pkg;

    localparam int DATA_WIDTH = 16;
    localparam logic [DATA_WIDTH-1:0] NULL_DEVICE = '0;

    // Phase codes are shared with fetch; keep the encoding fixed.
    typedef enum logic [2:0] {
        LIDLE           = 3'd0,
        LSOURCE_DEVICE  = 3'd1,
        LSOURCE_ADDRESS = 3'd2,
        LTARGET_DEVICE  = 3'd3,
        LTARGET_ADDRESS = 3'd4
    } phase_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] src_dev;
        logic [DATA_WIDTH-1:0] src_addr;
        logic [DATA_WIDTH-1:0] tgt_dev;
        logic [DATA_WIDTH-1:0] tgt_addr;
    } move_req_t;

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            LIDLE:           return LSOURCE_DEVICE;
            LSOURCE_DEVICE:  return LSOURCE_ADDRESS;
            LSOURCE_ADDRESS: return LTARGET_DEVICE;
            LTARGET_DEVICE:  return LTARGET_ADDRESS;
            default:         return LIDLE;
        endcase
    endfunction

endpackage

// File: rtl/move_issuer_if.sv
// Move-request channel: valid/ready handshake carrying source and target device/address.
interface move_issuer_if;
    import move_issuer_pkg::*;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] src_dev;
    logic [DATA_WIDTH-1:0] src_addr;
    logic [DATA_WIDTH-1:0] tgt_dev;
    logic [DATA_WIDTH-1:0] tgt_addr;

    modport master (output valid, src_dev, src_addr, tgt_dev, tgt_addr, input ready);
    modport slave  (input valid, src_dev, src_addr, tgt_dev, tgt_addr, output ready);
endinterface

// File: rtl/move_req_fifo.sv
// 2-entry FIFO of move requests; pop data is the registered head, visible the cycle after push.
// Backpressure: push ignored when full, pop ignored when empty; push+pop on one edge both happen.
module move_req_fifo #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/move_issuer.sv
// Serializes queued move requests into 5-word ir frames locked to the receiver phase; NOP frames when idle.
// Latency: a request accepted before a TGT_ADDR edge appears in the next frame; ready drops only when the 2-entry queue is full.
module move_issuer
    import move_issuer_pkg::*;
#(
    parameter int SEQ_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    move_issuer_if.slave          req,
    output logic [DATA_WIDTH-1:0] o_ir,
    output logic                  o_frame_start,
    output logic                  o_frame_done,
    output logic                  o_err_drop,
    output logic                  o_busy
);

    phase_e                phase_q;
    phase_e                phase_d;
    move_req_t             in_req;
    move_req_t             head;
    move_req_t             cur_q;
    logic                  frame_valid_q;
    logic [SEQ_W-1:0]      seq_q;
    logic [SEQ_W-1:0]      frame_seq_q;
    logic                  err_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  accept;
    logic                  is_null;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] header;

    assign in_req    = '{src_dev: req.src_dev, src_addr: req.src_addr,
                         tgt_dev: req.tgt_dev, tgt_addr: req.tgt_addr};
    assign req.ready = !fifo_full && !rst;
    assign accept    = req.valid && req.ready;
    assign is_null   = (in_req.src_dev == NULL_DEVICE) || (in_req.tgt_dev == NULL_DEVICE);
    assign push      = accept && !is_null;
    assign pop       = (phase_q == LTARGET_ADDRESS) && !fifo_empty;

    move_req_fifo #(.W($bits(move_req_t))) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (in_req),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        phase_d = next_phase(phase_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q       <= LIDLE;
            cur_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_seq_q   <= '0;
            seq_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            phase_q <= phase_d;
            err_q   <= accept && is_null;
            // The next frame is chosen on the edge that closes the current one.
            if (phase_q == LTARGET_ADDRESS) begin
                if (!fifo_empty) begin
                    cur_q         <= head;
                    frame_valid_q <= 1'b1;
                    frame_seq_q   <= seq_q;
                    seq_q         <= seq_q + SEQ_W'(1);
                end else begin
                    cur_q         <= '0;
                    frame_valid_q <= 1'b0;
                    frame_seq_q   <= '0;
                end
            end
        end
    end

    always_comb begin
        header                 = '0;
        header[DATA_WIDTH-1]   = frame_valid_q;
        header[SEQ_W-1:0]      = frame_seq_q;
    end

    always_comb begin
        o_ir = '0;
        if (!rst) begin
            case (phase_q)
                LIDLE:           o_ir = header;
                LSOURCE_DEVICE:  o_ir = cur_q.src_dev;
                LSOURCE_ADDRESS: o_ir = cur_q.src_addr;
                LTARGET_DEVICE:  o_ir = cur_q.tgt_dev;
                LTARGET_ADDRESS: o_ir = cur_q.tgt_addr;
                default:         o_ir = '0;
            endcase
        end
    end

    assign o_frame_start = rst || (phase_q == LIDLE);
    assign o_frame_done  = !rst && frame_valid_q && (phase_q == LTARGET_ADDRESS);
    assign o_err_drop    = !rst && err_q;
    assign o_busy        = !rst && (!fifo_empty || frame_valid_q);

endmodule

// File: tb/tb_move_issuer.sv
// Directed bench for move_issuer: frame timing, queueing, null drops, reset abort and seq wrap.
module tb_move_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] o_ir;
    logic        o_frame_start;
    logic        o_frame_done;
    logic        o_err_drop;
    logic        o_busy;
    int          checks = 0;
    int          failures = 0;

    move_issuer_if req_if ();

    move_issuer dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req_if),
        .o_ir          (o_ir),
        .o_frame_start (o_frame_start),
        .o_frame_done  (o_frame_done),
        .o_err_drop    (o_err_drop),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] sd, input logic [15:0] sa,
                         input logic [15:0] td, input logic [15:0] ta);
        req_if.valid    = v;
        req_if.src_dev  = sd;
        req_if.src_addr = sa;
        req_if.tgt_dev  = td;
        req_if.tgt_addr = ta;
    endtask

    // Leaves the bench at the middle of C0, the first cycle after reset release.
    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

        // Outputs while reset is held
        @(negedge clk);
        @(negedge clk);
        chk("rst_ir",    32'(o_ir),          32'h0);
        chk("rst_ready", 32'(req_if.ready),  32'h0);
        chk("rst_start", 32'(o_frame_start), 32'h1);
        chk("rst_done",  32'(o_frame_done),  32'h0);
        chk("rst_err",   32'(o_err_drop),    32'h0);
        chk("rst_busy",  32'(o_busy),        32'h0);

        // Idle: NOP frames only
        do_reset();
        for (int c = 0; c < 15; c++) begin
            chk($sformatf("idle_ir_c%0d", c),    32'(o_ir),          32'h0);
            chk($sformatf("idle_start_c%0d", c), 32'(o_frame_start), (c % 5 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("idle_busy_c%0d", c),  32'(o_busy),        32'h0);
            chk($sformatf("idle_ready_c%0d", c), 32'(req_if.ready),  32'h1);
            @(negedge clk);
        end

        // Single request accepted at C0
        do_reset();
        begin
            logic [15:0] exp_ir [11];
            exp_ir = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                       16'h8000, 16'h0003, 16'h0010, 16'h0005, 16'h0020, 16'h0};
            for (int c = 0; c <= 10; c++) begin
                chk($sformatf("single_ir_c%0d", c),   32'(o_ir),         32'(exp_ir[c]));
                chk($sformatf("single_done_c%0d", c), 32'(o_frame_done), (c == 9) ? 32'h1 : 32'h0);
                chk($sformatf("single_busy_c%0d", c), 32'(o_busy),       (c >= 1 && c <= 9) ? 32'h1 : 32'h0);
                if (c == 0) drive(1'b1, 16'h0003, 16'h0010, 16'h0005, 16'h0020);
                if (c == 1) drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
                @(negedge clk);
            end
        end

        // Three requests back to back: queue fills, third waits for a pop
        do_reset();
        begin
            logic exp_rdy [7];
            exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            for (int c = 0; c <= 16; c++) begin
                if (c <= 6)  chk($sformatf("three_ready_c%0d", c), 32'(req_if.ready), 32'(exp_rdy[c]));
                if (c == 5)  chk("three_hdr0",  32'(o_ir), 32'h8000);
                if (c == 6)  chk("three_src0",  32'(o_ir), 32'h0001);
                if (c == 9)  chk("three_done0", 32'(o_frame_done), 32'h1);
                if (c == 10) chk("three_hdr1",  32'(o_ir), 32'h8001);
                if (c == 11) chk("three_src1",  32'(o_ir), 32'h0005);
                if (c == 15) chk("three_hdr2",  32'(o_ir), 32'h8002);
                if (c == 16) chk("three_src2",  32'(o_ir), 32'h0009);
                if (c == 0) drive(1'b1, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
                if (c == 1) drive(1'b1, 16'h0005, 16'h0006, 16'h0007, 16'h0008);
                if (c == 2) drive(1'b1, 16'h0009, 16'h000A, 16'h000B, 16'h000C);
                if (c == 6) drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
                @(negedge clk);
            end
        end

        // Null target device: accepted, dropped, seq untouched
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            if (c == 1)  chk("null_err_c1",   32'(o_err_drop), 32'h1);
            if (c == 1)  chk("null_busy_c1",  32'(o_busy),     32'h0);
            if (c == 2)  chk("null_err_c2",   32'(o_err_drop), 32'h0);
            if (c == 5)  chk("null_nop_hdr",  32'(o_ir),       32'h0);
            if (c == 9)  chk("null_nop_done", 32'(o_frame_done), 32'h0);
            if (c == 10) chk("null_next_hdr", 32'(o_ir),       32'h8000);
            if (c == 11) chk("null_next_src", 32'(o_ir),       32'h0011);
            if (c == 14) chk("null_next_done", 32'(o_frame_done), 32'h1);
            if (c == 0) drive(1'b1, 16'h0001, 16'h0002, 16'h0000, 16'h0004);
            if (c == 1) drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
            if (c == 5) drive(1'b1, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
            if (c == 6) drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
            @(negedge clk);
        end

        // Reset during SRC_ADDR of a valid frame with one request still queued
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            if (c == 5) chk("abort_hdr",     32'(o_ir), 32'h8000);
            if (c == 7) chk("abort_srcaddr", 32'(o_ir), 32'h0002);
            if (c == 0) drive(1'b1, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
            if (c == 1) drive(1'b1, 16'h0005, 16'h0006, 16'h0007, 16'h0008);
            if (c == 2) drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
            if (c < 7) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("abort_in_rst_ir",    32'(o_ir),         32'h0);
        chk("abort_in_rst_ready", 32'(req_if.ready), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_c0_start", 32'(o_frame_start), 32'h1);
        chk("abort_c0_busy",  32'(o_busy),        32'h0);
        chk("abort_c0_ready", 32'(req_if.ready),  32'h1);
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("abort_ir_c%0d", c), 32'(o_ir), 32'h0);
            @(negedge clk);
        end

        // 257 consecutive valid frames: header sequence wraps back to 0
        do_reset();
        drive(1'b1, 16'h0042, 16'h0043, 16'h0044, 16'h0045);
        for (int c = 0; c <= 5 + 5 * 256; c++) begin
            if (c >= 5 && (c - 5) % 5 == 0)
                chk($sformatf("wrap_hdr_f%0d", (c - 5) / 5), 32'(o_ir),
                    32'h8000 | 32'(((c - 5) / 5) % 256));
            @(negedge clk);
        end
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
